// File: rtl/seven_seg_pkg.sv
// Segment patterns and digit/segment types shared by the detection counter and detector displays.
// Patterns are 7-bit active-low g..a; polarity and decimal point are added by seg_apply_polarity.
package seven_seg_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [7:0] seg_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ERR   = 7'b0000110;

    // Decimal point is always off; inversion covers all 8 bits, dp included.
    function automatic seg_t seg_apply_polarity(input logic [6:0] pattern, input bit active_low);
        seg_t raw;
        raw = {1'b1, pattern};
        return active_low ? raw : ~raw;
    endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Purpose: BCD digit (or blank) to 8-bit segment pattern with selectable polarity.
// Latency: combinational; the parent registers the output.
// Backpressure: none, pure function of its inputs.
module seg7_encoder
    import seven_seg_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  bcd_t digit,
    input  logic blank,
    output seg_t seg
);

    logic [6:0] pattern;

    always_comb begin
        pattern = SEG_ERR;
        if (blank) begin
            pattern = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    pattern = SEG_0;
                4'd1:    pattern = SEG_1;
                4'd2:    pattern = SEG_2;
                4'd3:    pattern = SEG_3;
                4'd4:    pattern = SEG_4;
                4'd5:    pattern = SEG_5;
                4'd6:    pattern = SEG_6;
                4'd7:    pattern = SEG_7;
                4'd8:    pattern = SEG_8;
                4'd9:    pattern = SEG_9;
                default: pattern = SEG_ERR;
            endcase
        end
    end

    assign seg = seg_apply_polarity(pattern, SEG_ACTIVE_LOW);

endmodule

// File: rtl/detect_count_display.sv
// Purpose: two-digit BCD count of detector strobes with 7-segment drive; DETECT_COUNT_SATURATE_EN holds at 99.
// Latency: count_bcd/ovf update at the strobe edge, disp0/disp1 one edge later.
// Backpressure: none; z is consumed as a level every cycle, clr > ena&&z > hold.
module detect_count_display
    import seven_seg_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       clr,
    input  logic       z,
    output logic [7:0] disp0,
    output logic [7:0] disp1,
    output logic [7:0] count_bcd,
    output logic       ovf
);

    localparam seg_t DISP0_RST = seg_apply_polarity(SEG_0, SEG_ACTIVE_LOW);
    localparam seg_t DISP1_RST = seg_apply_polarity(BLANK_LEADING ? SEG_BLANK : SEG_0,
                                                    SEG_ACTIVE_LOW);

    bcd_t ones, tens, ones_nxt, tens_nxt;
    logic ovf_q, ovf_nxt;
    seg_t seg0, seg1, disp0_q, disp1_q;

    always_comb begin
        ones_nxt = ones;
        tens_nxt = tens;
        ovf_nxt  = ovf_q;
        if (clr) begin
            ones_nxt = 4'd0;
            tens_nxt = 4'd0;
            ovf_nxt  = 1'b0;
        end else if (ena && z) begin
            if (ones < 4'd9) begin
                ones_nxt = ones + 4'd1;
            end else if (tens < 4'd9) begin
                ones_nxt = 4'd0;
                tens_nxt = tens + 4'd1;
            end else begin
`ifdef DETECT_COUNT_SATURATE_EN
                ovf_nxt  = 1'b1;
`else
                ones_nxt = 4'd0;
                tens_nxt = 4'd0;
                ovf_nxt  = 1'b1;
`endif
            end
        end
    end

    seg7_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc_ones (
        .digit (ones),
        .blank (1'b0),
        .seg   (seg0)
    );

    seg7_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc_tens (
        .digit (tens),
        .blank (BLANK_LEADING && (tens == 4'd0)),
        .seg   (seg1)
    );

    // Display registers load reset patterns directly so no stale digit survives a reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ones    <= 4'd0;
            tens    <= 4'd0;
            ovf_q   <= 1'b0;
            disp0_q <= DISP0_RST;
            disp1_q <= DISP1_RST;
        end else begin
            ones    <= ones_nxt;
            tens    <= tens_nxt;
            ovf_q   <= ovf_nxt;
            disp0_q <= seg0;
            disp1_q <= seg1;
        end
    end

    assign count_bcd = {tens, ones};
    assign ovf       = ovf_q;
    assign disp0     = disp0_q;
    assign disp1     = disp1_q;

endmodule

// File: tb/tb_detect_count_display.sv
// Directed bench for detect_count_display with default parameters; follows DETECT_COUNT_SATURATE_EN if defined.
module tb_detect_count_display;

    logic       clk = 1'b0;
    logic       rst, ena, clr, z;
    logic [7:0] disp0, disp1, count_bcd;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    detect_count_display dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .clr       (clr),
        .z         (z),
        .disp0     (disp0),
        .disp1     (disp1),
        .count_bcd (count_bcd),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, ena, clr, z;
        logic [7:0] cnt;
        logic       ovf;
        logic [7:0] d0, d1;
    } vec_t;

    // Bench-side model state for the longer pulse runs.
    int m_cnt, m_prev;
    logic m_ovf;

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'h86;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic c, input logic zz);
        rst = r; ena = e; clr = c; z = zz;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [7:0] exp_cnt;
        exp_cnt = {4'(m_cnt / 10), 4'(m_cnt % 10)};
        check({tag, "_cnt"}, count_bcd, exp_cnt);
        check({tag, "_ovf"}, {7'd0, ovf}, {7'd0, m_ovf});
        check({tag, "_d0"}, disp0, seg_of(m_prev % 10));
        check({tag, "_d1"}, disp1, (m_prev / 10 == 0) ? 8'hFF : seg_of(m_prev / 10));
    endtask

    task automatic run(input string tag, input int n, input logic e, input logic zz);
        for (int i = 0; i < n; i++) begin
            step(1'b1, e, 1'b0, zz);
            m_prev = m_cnt;
            if (e && zz) begin
                if (m_cnt == 99) begin
`ifndef DETECT_COUNT_SATURATE_EN
                    m_cnt = 0;
`endif
                    m_ovf = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
            check_model($sformatf("%s%0d", tag, i));
        end
    endtask

    task automatic do_clr(input string tag);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        m_prev = m_cnt;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        check_model(tag);
    endtask

    vec_t vecs[10];

    initial begin
        rst = 1'b0; ena = 1'b0; clr = 1'b0; z = 1'b0;

        //           rst   ena   clr   z     cnt    ovf   disp0  disp1
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hC0, 8'hFF};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'hC0, 8'hFF};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 8'hC0, 8'hFF};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 8'hF9, 8'hFF};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 8'hF9, 8'hFF};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 8'hF9, 8'hFF};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 8'hA4, 8'hFF};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 8'hB0, 8'hFF};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'hB0, 8'hFF};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hC0, 8'hFF};

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rst, vecs[i].ena, vecs[i].clr, vecs[i].z);
            check($sformatf("vec%0d_cnt", i), count_bcd, vecs[i].cnt);
            check($sformatf("vec%0d_ovf", i), {7'd0, ovf}, {7'd0, vecs[i].ovf});
            check($sformatf("vec%0d_d0", i), disp0, vecs[i].d0);
            check($sformatf("vec%0d_d1", i), disp1, vecs[i].d1);
        end

        m_cnt = 0; m_prev = 0; m_ovf = 1'b0;

        // Ten isolated pulses carry into the tens digit.
        for (int p = 0; p < 10; p++) begin
            run($sformatf("pulse%0d_", p), 1, 1'b1, 1'b1);
            run($sformatf("gap%0d_", p), 1, 1'b1, 1'b0);
        end
        run("hold3_", 3, 1'b1, 1'b1);
        run("gated_", 5, 1'b0, 1'b1);
        run("idle_", 1, 1'b1, 1'b0);
        do_clr("clr_a");

`ifdef DETECT_COUNT_SATURATE_EN
        run("sat_", 105, 1'b1, 1'b1);
        run("sat_idle_", 1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("midrst_cnt", count_bcd, 8'h00);
        check("midrst_ovf", {7'd0, ovf}, 8'h00);
        check("midrst_d0", disp0, 8'hC0);
        check("midrst_d1", disp1, 8'hFF);
        m_cnt = 0; m_prev = 0; m_ovf = 1'b0;
        run("post_rst_", 2, 1'b1, 1'b1);
`else
        run("wrap_", 100, 1'b1, 1'b1);
        run("wrap_more_", 2, 1'b1, 1'b1);
        run("wrap_idle_", 1, 1'b1, 1'b0);
        do_clr("clr_ovf");
        run("after_clr_", 1, 1'b1, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
